// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register of the five-stage MIPS core.
// Captures the MEM-stage bundle each advancing cycle and, from the registered
// copy only, extracts load bytes/halfwords and selects the register-file write
// data, forwarding qualifier and W-stage Tnew.
//
// Ports:
//   clk, clr (sync active-high reset), en (advance), flush (bubble, below clr)
//   *_m inputs : instruction, PC+8, ALU result/address, raw DM word, dest reg,
//                write enable, load type, writeback select, Tnew
//   *_w outputs: instr_w, pc8_w, wa_w, rf_we_w (gated for $0), wd_w
//                (combinational from registers), tnew_w, fwd_ok_w
//
// Optional feature: define WB_TRACE_EN to print a register-write trace line on
// every rising edge where rf_we_w=1 and clr=0.
module mem_wb_stage #(
  parameter int unsigned     DW        = 32,
  parameter logic [DW-1:0]   RESET_PC8 = 32'h0000_3008
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic          flush,
  input  logic [DW-1:0] instr_m,
  input  logic [DW-1:0] pc8_m,
  input  logic [DW-1:0] alu_m,
  input  logic [DW-1:0] dr_m,
  input  logic [4:0]    wa_m,
  input  logic          rf_we_m,
  input  logic [2:0]    ld_type_m,
  input  logic [1:0]    wd_sel_m,
  input  logic [1:0]    tnew_m,
  output logic [DW-1:0] instr_w,
  output logic [DW-1:0] pc8_w,
  output logic [4:0]    wa_w,
  output logic          rf_we_w,
  output logic [DW-1:0] wd_w,
  output logic [1:0]    tnew_w,
  output logic          fwd_ok_w
);

  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LB  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LH  = 3'd4;

  logic [DW-1:0] instr_q, instr_d;
  logic [DW-1:0] pc8_q,   pc8_d;
  logic [DW-1:0] alu_q,   alu_d;
  logic [DW-1:0] dr_q,    dr_d;
  logic [4:0]    wa_q,    wa_d;
  logic          rf_we_q, rf_we_d;
  logic [2:0]    ld_type_q, ld_type_d;
  logic [1:0]    wd_sel_q,  wd_sel_d;
  logic [1:0]    tnew_q,    tnew_d;

  // Next-state: flush bubbles, en captures (Tnew ages by one, saturating), else hold.
  always_comb begin
    instr_d   = instr_q;
    pc8_d     = pc8_q;
    alu_d     = alu_q;
    dr_d      = dr_q;
    wa_d      = wa_q;
    rf_we_d   = rf_we_q;
    ld_type_d = ld_type_q;
    wd_sel_d  = wd_sel_q;
    tnew_d    = tnew_q;
    if (flush) begin
      instr_d   = '0;
      pc8_d     = RESET_PC8;
      alu_d     = '0;
      dr_d      = '0;
      wa_d      = '0;
      rf_we_d   = 1'b0;
      ld_type_d = '0;
      wd_sel_d  = '0;
      tnew_d    = '0;
    end else if (en) begin
      instr_d   = instr_m;
      pc8_d     = pc8_m;
      alu_d     = alu_m;
      dr_d      = dr_m;
      wa_d      = wa_m;
      rf_we_d   = rf_we_m;
      ld_type_d = ld_type_m;
      wd_sel_d  = wd_sel_m;
      tnew_d    = (tnew_m == 2'd0) ? 2'd0 : 2'(tnew_m - 2'd1);
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      instr_q   <= '0;
      pc8_q     <= RESET_PC8;
      alu_q     <= '0;
      dr_q      <= '0;
      wa_q      <= '0;
      rf_we_q   <= 1'b0;
      ld_type_q <= '0;
      wd_sel_q  <= '0;
      tnew_q    <= '0;
    end else begin
      instr_q   <= instr_d;
      pc8_q     <= pc8_d;
      alu_q     <= alu_d;
      dr_q      <= dr_d;
      wa_q      <= wa_d;
      rf_we_q   <= rf_we_d;
      ld_type_q <= ld_type_d;
      wd_sel_q  <= wd_sel_d;
      tnew_q    <= tnew_d;
    end
  end

  // Load extraction, little-endian; low address bits beyond the access size are ignored.
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [DW-1:0] ld_val;

  always_comb begin
    ld_byte = 8'h00;
    ld_half = alu_q[1] ? dr_q[31:16] : dr_q[15:0];
    ld_val  = dr_q;
    case (alu_q[1:0])
      2'd0:    ld_byte = dr_q[7:0];
      2'd1:    ld_byte = dr_q[15:8];
      2'd2:    ld_byte = dr_q[23:16];
      default: ld_byte = dr_q[31:24];
    endcase
    case (ld_type_q)
      LD_LBU:  ld_val = {24'h000000, ld_byte};
      LD_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      LD_LHU:  ld_val = {16'h0000, ld_half};
      LD_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      default: ld_val = dr_q;
    endcase
  end

  // Writeback source select.
  always_comb begin
    wd_w = '0;
    case (wd_sel_q)
      2'd0:    wd_w = alu_q;
      2'd1:    wd_w = ld_val;
      2'd2:    wd_w = pc8_q;
      default: wd_w = '0;
    endcase
  end

  // $0 is never written nor forwarded.
  assign instr_w  = instr_q;
  assign pc8_w    = pc8_q;
  assign wa_w     = wa_q;
  assign rf_we_w  = rf_we_q & (wa_q != 5'd0);
  assign tnew_w   = tnew_q;
  assign fwd_ok_w = rf_we_w & (tnew_q == 2'd0);

`ifdef WB_TRACE_EN
  // Register-write trace line for the grading log.
  always @(posedge clk) begin
    if (rf_we_w && !clr)
      $display("%d@%h: $%d <= %h", $time, pc8_w - 32'd8, wa_w, wd_w);
  end
`else
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        clr = 1'b0, en = 1'b0, flush = 1'b0;
  logic [31:0] instr_m = '0, pc8_m = '0, alu_m = '0, dr_m = '0;
  logic [4:0]  wa_m = '0;
  logic        rf_we_m = 1'b0;
  logic [2:0]  ld_type_m = '0;
  logic [1:0]  wd_sel_m = '0, tnew_m = '0;
  logic [31:0] instr_w, pc8_w, wd_w;
  logic [4:0]  wa_w;
  logic        rf_we_w, fwd_ok_w;
  logic [1:0]  tnew_w;

  int checks = 0;
  int errors = 0;

  mem_wb_stage dut (
    .clk(clk), .clr(clr), .en(en), .flush(flush),
    .instr_m(instr_m), .pc8_m(pc8_m), .alu_m(alu_m), .dr_m(dr_m),
    .wa_m(wa_m), .rf_we_m(rf_we_m), .ld_type_m(ld_type_m),
    .wd_sel_m(wd_sel_m), .tnew_m(tnew_m),
    .instr_w(instr_w), .pc8_w(pc8_w), .wa_w(wa_w), .rf_we_w(rf_we_w),
    .wd_w(wd_w), .tnew_w(tnew_w), .fwd_ok_w(fwd_ok_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr, flush, en;
    logic [31:0] instr, pc8, alu, dr;
    logic [4:0]  wa;
    logic        we;
    logic [2:0]  ld;
    logic [1:0]  sel, tnew;
    logic [31:0] e_instr, e_pc8;
    logic [4:0]  e_wa;
    logic        e_we;
    logic [31:0] e_wd;
    logic [1:0]  e_tnew;
    logic        e_fwd;
  } vec_t;

  // Captured MEM bundle as the reference model sees it.
  typedef struct {
    logic [31:0] instr, pc8, alu, dr;
    logic [4:0]  wa;
    logic        we;
    logic [2:0]  ld;
    logic [1:0]  sel, tnew;
  } bundle_t;

  vec_t    tbl[19];
  bundle_t mdl;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    clr = v.clr; flush = v.flush; en = v.en;
    instr_m = v.instr; pc8_m = v.pc8; alu_m = v.alu; dr_m = v.dr;
    wa_m = v.wa; rf_we_m = v.we; ld_type_m = v.ld; wd_sel_m = v.sel; tnew_m = v.tnew;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [31:0] ei, input logic [31:0] ep,
                            input logic [4:0] ewa, input logic ewe, input logic [31:0] ewd,
                            input logic [1:0] etn, input logic efw);
    chk({tag, ".instr_w"},  instr_w, ei);
    chk({tag, ".pc8_w"},    pc8_w, ep);
    chk({tag, ".wa_w"},     32'(wa_w), 32'(ewa));
    chk({tag, ".rf_we_w"},  32'(rf_we_w), 32'(ewe));
    chk({tag, ".wd_w"},     wd_w, ewd);
    chk({tag, ".tnew_w"},   32'(tnew_w), 32'(etn));
    chk({tag, ".fwd_ok_w"}, 32'(fwd_ok_w), 32'(efw));
  endtask

  // Load value from byte/halfword arithmetic on the word.
  function automatic logic [31:0] load_value(input logic [2:0] ld, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> ((addr % 4) * 8)) & 32'hFF;
    h = (word >> (((addr / 2) % 2) * 16)) & 32'hFFFF;
    case (ld)
      3'd1:    return b;
      3'd2:    return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'd3:    return h;
      3'd4:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      default: return word;
    endcase
  endfunction

  initial begin
    //             clr fl en instr          pc8           alu           dr            wa  we ld sel tn | e_instr       e_pc8        e_wa e_we e_wd          e_tn e_fwd
    tbl[0]  = '{1'b1,1'b0,1'b1, 32'hDEAD_BEEF, 32'h0000_1234, 32'h0000_0005, 32'h0000_0077, 5'd9, 1'b1, 3'd0, 2'd0, 2'd2,
                32'h0, 32'h0000_3008, 5'd0, 1'b0, 32'h0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0,1'b0,1'b1, 32'h8108_0002, 32'h0000_3014, 32'h0000_0002, 32'h80FF_7F01, 5'd8, 1'b1, 3'd2, 2'd1, 2'd0,
                32'h8108_0002, 32'h0000_3014, 5'd8, 1'b1, 32'hFFFF_FFFF, 2'd0, 1'b1};
    tbl[2]  = '{1'b0,1'b0,1'b1, 32'h9108_0002, 32'h0000_3014, 32'h0000_0002, 32'h80FF_7F01, 5'd8, 1'b1, 3'd1, 2'd1, 2'd0,
                32'h9108_0002, 32'h0000_3014, 5'd8, 1'b1, 32'h0000_00FF, 2'd0, 1'b1};
    tbl[3]  = '{1'b0,1'b0,1'b1, 32'h8508_0002, 32'h0000_3018, 32'h0000_0002, 32'h80FF_7F01, 5'd8, 1'b1, 3'd4, 2'd1, 2'd0,
                32'h8508_0002, 32'h0000_3018, 5'd8, 1'b1, 32'hFFFF_80FF, 2'd0, 1'b1};
    tbl[4]  = '{1'b0,1'b0,1'b1, 32'h9508_0000, 32'h0000_301C, 32'h0000_0000, 32'h80FF_7F01, 5'd8, 1'b1, 3'd3, 2'd1, 2'd0,
                32'h9508_0000, 32'h0000_301C, 5'd8, 1'b1, 32'h0000_7F01, 2'd0, 1'b1};
    tbl[5]  = '{1'b0,1'b0,1'b1, 32'h8C08_0003, 32'h0000_3020, 32'h0000_0003, 32'h80FF_7F01, 5'd8, 1'b1, 3'd0, 2'd1, 2'd0,
                32'h8C08_0003, 32'h0000_3020, 5'd8, 1'b1, 32'h80FF_7F01, 2'd0, 1'b1};
    tbl[6]  = '{1'b0,1'b0,1'b1, 32'h8C08_0000, 32'h0000_3024, 32'h0000_0000, 32'h80FF_7F01, 5'd8, 1'b1, 3'd5, 2'd1, 2'd0,
                32'h8C08_0000, 32'h0000_3024, 5'd8, 1'b1, 32'h80FF_7F01, 2'd0, 1'b1};
    tbl[7]  = '{1'b0,1'b0,1'b1, 32'h0123_4567, 32'h0000_3028, 32'h1111_2222, 32'h0, 5'd5, 1'b1, 3'd0, 2'd0, 2'd2,
                32'h0123_4567, 32'h0000_3028, 5'd5, 1'b1, 32'h1111_2222, 2'd1, 1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b0, 32'hAAAA_AAAA, 32'h0000_4000, 32'hAAAA_0000, 32'h5, 5'd7, 1'b1, 3'd1, 2'd2, 2'd3,
                32'h0123_4567, 32'h0000_3028, 5'd5, 1'b1, 32'h1111_2222, 2'd1, 1'b0};
    tbl[9]  = tbl[8];
    tbl[10] = tbl[8];
    tbl[11] = '{1'b0,1'b0,1'b1, 32'h0000_0021, 32'h0000_302C, 32'h0000_0033, 32'h0, 5'd5, 1'b1, 3'd0, 2'd0, 2'd0,
                32'h0000_0021, 32'h0000_302C, 5'd5, 1'b1, 32'h0000_0033, 2'd0, 1'b1};
    tbl[12] = '{1'b0,1'b0,1'b1, 32'h0C00_0C00, 32'h0000_3010, 32'h0000_0001, 32'h0, 5'd31, 1'b1, 3'd0, 2'd2, 2'd0,
                32'h0C00_0C00, 32'h0000_3010, 5'd31, 1'b1, 32'h0000_3010, 2'd0, 1'b1};
    tbl[13] = '{1'b0,1'b0,1'b1, 32'h0C00_0C00, 32'h0000_3010, 32'h0000_0001, 32'h0, 5'd0, 1'b1, 3'd0, 2'd2, 2'd0,
                32'h0C00_0C00, 32'h0000_3010, 5'd0, 1'b0, 32'h0000_3010, 2'd0, 1'b0};
    tbl[14] = '{1'b0,1'b1,1'b1, 32'h0C00_0C00, 32'h0000_3010, 32'h0000_0001, 32'h0, 5'd31, 1'b1, 3'd0, 2'd2, 2'd0,
                32'h0, 32'h0000_3008, 5'd0, 1'b0, 32'h0, 2'd0, 1'b0};
    tbl[15] = '{1'b0,1'b0,1'b1, 32'h0000_0055, 32'h0000_3030, 32'h0000_0055, 32'h0, 5'd4, 1'b1, 3'd0, 2'd3, 2'd0,
                32'h0000_0055, 32'h0000_3030, 5'd4, 1'b1, 32'h0, 2'd0, 1'b1};
    tbl[16] = '{1'b0,1'b0,1'b1, 32'h0000_0066, 32'h0000_3034, 32'h0000_0066, 32'h0, 5'd4, 1'b1, 3'd0, 2'd0, 2'd3,
                32'h0000_0066, 32'h0000_3034, 5'd4, 1'b1, 32'h0000_0066, 2'd2, 1'b0};
    tbl[17] = '{1'b1,1'b1,1'b1, 32'h0000_0077, 32'h0000_3038, 32'h0000_0077, 32'h0, 5'd6, 1'b1, 3'd0, 2'd0, 2'd0,
                32'h0, 32'h0000_3008, 5'd0, 1'b0, 32'h0, 2'd0, 1'b0};
    tbl[18] = '{1'b0,1'b0,1'b1, 32'h0000_0088, 32'h0000_303C, 32'h0000_0088, 32'h0, 5'd6, 1'b1, 3'd0, 2'd0, 2'd1,
                32'h0000_0088, 32'h0000_303C, 5'd6, 1'b1, 32'h0000_0088, 2'd0, 1'b1};

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i]);
      check_outs($sformatf("vec%0d", i), tbl[i].e_instr, tbl[i].e_pc8, tbl[i].e_wa,
                 tbl[i].e_we, tbl[i].e_wd, tbl[i].e_tnew, tbl[i].e_fwd);
    end

    // Randomized run against the bundle model; start from a known clear.
    mdl = '{instr: 32'h0, pc8: 32'h3008, alu: 32'h0, dr: 32'h0, wa: 5'd0, we: 1'b0,
            ld: 3'd0, sel: 2'd0, tnew: 2'd0};
    begin
      vec_t r;
      r = tbl[0];
      drive(r);
    end
    for (int n = 0; n < 400; n++) begin
      vec_t r;
      logic [31:0] exp_wd;
      logic        exp_we;
      r = tbl[0];
      r.clr   = ($urandom_range(0, 19) == 0);
      r.flush = ($urandom_range(0, 14) == 0);
      r.en    = ($urandom_range(0, 3) != 0);
      r.instr = $urandom; r.pc8 = $urandom; r.alu = $urandom; r.dr = $urandom;
      r.wa    = 5'($urandom_range(0, 31));
      r.we    = 1'($urandom_range(0, 1));
      r.ld    = 3'($urandom_range(0, 7));
      r.sel   = 2'($urandom_range(0, 3));
      r.tnew  = 2'($urandom_range(0, 3));
      if (r.clr || r.flush)
        mdl = '{instr: 32'h0, pc8: 32'h3008, alu: 32'h0, dr: 32'h0, wa: 5'd0, we: 1'b0,
                ld: 3'd0, sel: 2'd0, tnew: 2'd0};
      else if (r.en)
        mdl = '{instr: r.instr, pc8: r.pc8, alu: r.alu, dr: r.dr, wa: r.wa, we: r.we,
                ld: r.ld, sel: r.sel, tnew: (r.tnew == 2'd0) ? 2'd0 : r.tnew - 2'd1};
      drive(r);
      case (mdl.sel)
        2'd0:    exp_wd = mdl.alu;
        2'd1:    exp_wd = load_value(mdl.ld, mdl.alu, mdl.dr);
        2'd2:    exp_wd = mdl.pc8;
        default: exp_wd = 32'h0;
      endcase
      exp_we = mdl.we && (mdl.wa != 5'd0);
      check_outs($sformatf("rnd%0d", n), mdl.instr, mdl.pc8, mdl.wa, exp_we, exp_wd,
                 mdl.tnew, exp_we && (mdl.tnew == 2'd0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register of the five-stage MIPS core; sits directly downstream of the data memory.
- Each cycle it captures the MEM-stage bundle: instruction, PC+8, ALU result, raw DM read word, destination register, register-file write enable, load type, writeback-source select and Tnew.
- Its combinational output side performs load byte/halfword extraction with sign/zero extension and selects the final register-file write data, the forwarding value and the hazard-unit view of the W stage.

Parameters:
- DW, 32, datapath width; only 32 is supported.
- RESET_PC8, 32'h0000_3008, value `pc8_w` takes on reset/flush (text base 0x3000 + 8).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clr  in  1  synchronous active-high reset; clears every register on the next rising edge.
- en  in  1  advance enable; 1 = capture M inputs, 0 = hold all registers.
- flush  in  1  synchronous bubble insert; same effect as `clr`, lower priority.
- instr_m  in  32  MEM-stage instruction word.
- pc8_m  in  32  MEM-stage PC+8.
- alu_m  in  32  ALU result, which is also the DM address.
- dr_m  in  32  raw DM read word at `alu_m[11:2]`.
- wa_m  in  5  destination register number.
- rf_we_m  in  1  register-file write enable.
- ld_type_m  in  3  0=LW 1=LBU 2=LB 3=LHU 4=LH, 5-7 treated as LW.
- wd_sel_m  in  2  writeback source: 0=ALU 1=MEM 2=PC8 3=zero.
- tnew_m  in  2  cycles until result ready, as seen in M.
- instr_w  out  32  registered instruction.
- pc8_w  out  32  registered PC+8.
- wa_w  out  5  registered destination register.
- rf_we_w  out  1  registered write enable, gated to 0 when `wa_w`==0.
- wd_w  out  32  final register-file write data (combinational from registers).
- tnew_w  out  2  registered Tnew.
- fwd_ok_w  out  1  `rf_we_w` & (`tnew_w`==0); W value forwardable.

Behaviour:
- Register priority on each rising edge: `clr` > `flush` > `en` > hold.
- Clear state (`clr` or `flush`):
  - `instr`, `alu`, `dr`, `wa`, `rf_we`, `ld_type`, `wd_sel`, `tnew` = 0.
  - `pc8` = RESET_PC8.
  - Outputs after clear: `instr_w`=0, `pc8_w`=RESET_PC8, `wa_w`=0, `rf_we_w`=0, `wd_w`=0, `tnew_w`=0, `fwd_ok_w`=0.
- `clr` or `flush` in the same cycle as `en` wins; the incoming instruction is discarded.
- `en`=1: all fields captured with latency 1; `tnew_w` <= (`tnew_m`==0) ? 0 : `tnew_m`-1, saturating, never wraps to 3.
- `en`=0: every register holds, including `tnew`; no decrement while held.
- Load extraction uses the registered address, `off` = `alu[1:0]`:
  - LBU = zero-extend of `dr` byte `off`.
  - LB = sign-extend of the same byte.
  - LHU/LH select halfword `alu[1]`, zero- or sign-extended.
  - LW returns `dr` unchanged.
  - Byte order is little-endian: byte 0 = `dr[7:0]`.
- Misaligned halfword (`alu[0]`=1) or word (`alu[1:0]`!=0) access is not trapped: bit 0 (and bit 1 for LW) is ignored.
- `wd_w` source:
  - `wd_sel`=0: `alu`.
  - `wd_sel`=1: extracted load value.
  - `wd_sel`=2: `pc8`.
  - `wd_sel`=3: 32'h0.
- `rf_we_w` is forced to 0 for `wa_w`==0, so $0 is never written or forwarded.
- No combinational path from any *_m input to any output.

Optional Feature:
- Macro `WB_TRACE_EN`.
- Defined: at every rising edge where `rf_we_w`=1 and `clr`=0, print via `$display` exactly `"%d@%h: $%d <= %h"` with `$time`, `pc8_w`-8, `wa_w`, `wd_w`. This is the register-write trace line of the grading log.
- Undefined: no display statements compiled; behaviour otherwise identical.

Test Plan:
- Reset: hold `clr`=1 one cycle with arbitrary inputs and `en`=1 -> `pc8_w`=32'h3008, `rf_we_w`=0, `wd_w`=0, `tnew_w`=0, `fwd_ok_w`=0.
- LB sign-extend: `dr_m`=32'h80FF_7F01, `alu_m`=32'h0000_0002, `ld_type_m`=2, `wd_sel_m`=1, `wa_m`=8, `rf_we_m`=1, `en`=1 -> next cycle `wd_w`=32'hFFFF_FFFF.
- LBU: same inputs with `ld_type_m`=1 -> `wd_w`=32'h0000_00FF.
- LH, `alu_m`=2: `ld_type_m`=4 -> `wd_w`=32'hFFFF_80FF.
- LHU, `alu_m`=0: `ld_type_m`=3 -> `wd_w`=32'h0000_7F01.
- Tnew/hold: `tnew_m`=2, `en`=1 -> `tnew_w`=1, `fwd_ok_w`=0. Then `en`=0 for 3 cycles -> `tnew_w` stays 1. Then `tnew_m`=0, `en`=1 -> `tnew_w`=0, `fwd_ok_w`=1.
- $0 and flush:
  - JAL-type (`wd_sel_m`=2, `pc8_m`=32'h3010, `wa_m`=31) -> `wd_w`=32'h3010, `rf_we_w`=1.
  - Same with `wa_m`=0 -> `rf_we_w`=0.
  - `flush`=1 together with `en`=1 -> bubble, `instr_w`=0, `rf_we_w`=0.
